wf_window_draw: RTL

WF_WINDOW_DRAW -- requirements
Module: wf_window_draw

---
 rtl/wf_window_draw.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wf_window_draw.sv
// wf_window_draw: two-stage pixel pipeline that classifies each active pixel
// against a frame-latched window. It reports in-window, trace and outline
// hits, and drives the waveform RAM read address for the trace lookup.
module wf_window_draw (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] start_x,
   input  logic [9:0] end_x,
   input  logic [9:0] start_y,
   input  logic [9:0] end_y,
   input  logic       frame_start,
   input  logic       pix_valid,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic [9:0] sample_addr,
   input  logic [7:0] sample_data,
   output logic       in_win,
   output logic       draw,
   output logic       border,
   output logic       limits_err
);

   localparam logic [9:0] DEF_SX = 10'd0;
   localparam logic [9:0] DEF_EX = 10'd639;
   localparam logic [9:0] DEF_SY = 10'd0;
   localparam logic [9:0] DEF_EY = 10'd479;

   // Inclusive range test shared by both axes.
   function automatic logic in_range(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
      in_range = (v >= lo) && (v <= hi);
   endfunction

   // Shadow limits and error flag.
   logic [9:0] sx_q, ex_q, sy_q, ey_q;
   logic [9:0] sx_d, ex_d, sy_d, ey_d;
   logic       err_q, err_d;

   // Stage 1 registers. Window limits travel with the pixel, so a frame_start
   // landing between stages cannot mix old and new limits for one pixel.
   logic       win1_q;
   logic [9:0] x1_q, y1_q;
   logic [9:0] sx1_q, ex1_q, sy1_q, ey1_q;
   logic [9:0] addr1_q;

   // Stage 2 (output) registers.
   logic       in_win_q, draw_q, border_q;

   // Stage 0 and stage 1 combinational results.
   logic        limits_ok_s;
   logic        win0_s;
   logic [9:0]  addr0_s;
   logic [9:0]  span_s;
   logic [17:0] prod_s;
   logic [9:0]  wave_y_s;
   logic        edge1_s;
   logic        draw1_s;

   // Shadow next-state: load legal limits on frame_start, otherwise hold.
   always_comb begin
      sx_d        = sx_q;
      ex_d        = ex_q;
      sy_d        = sy_q;
      ey_d        = ey_q;
      err_d       = err_q;
      limits_ok_s = (start_x <= end_x) && (start_y <= end_y);
      if (frame_start) begin
         if (limits_ok_s) begin
            sx_d  = start_x;
            ex_d  = end_x;
            sy_d  = start_y;
            ey_d  = end_y;
            err_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         err_d = err_q;
      end
   end

   // Shadow limit registers; reset to the full 640x480 frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sx_q  <= DEF_SX;
         ex_q  <= DEF_EX;
         sy_q  <= DEF_SY;
         ey_q  <= DEF_EY;
         err_q <= 1'b0;
      end else begin
         sx_q  <= sx_d;
         ex_q  <= ex_d;
         sy_q  <= sy_d;
         ey_q  <= ey_d;
         err_q <= err_d;
      end
   end

   // Stage 0 window test and RAM address; uses the pre-update shadows.
   always_comb begin
      win0_s  = 1'b0;
      addr0_s = 10'd0;
      if (pix_valid && in_range(x, sx_q, ex_q) && in_range(y, sy_q, ey_q)) begin
         win0_s  = 1'b1;
         addr0_s = x - sx_q;
      end else begin
         win0_s  = 1'b0;
         addr0_s = 10'd0;
      end
   end

   // Stage 1 pipeline registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win1_q  <= 1'b0;
         x1_q    <= 10'd0;
         y1_q    <= 10'd0;
         sx1_q   <= DEF_SX;
         ex1_q   <= DEF_EX;
         sy1_q   <= DEF_SY;
         ey1_q   <= DEF_EY;
         addr1_q <= 10'd0;
      end else begin
         win1_q  <= win0_s;
         x1_q    <= x;
         y1_q    <= y;
         sx1_q   <= sx_q;
         ex1_q   <= ex_q;
         sy1_q   <= sy_q;
         ey1_q   <= ey_q;
         addr1_q <= addr0_s;
      end
   end

   // Stage 1 trace height and outline test. The scaled offset never exceeds
   // the span, so wave_y stays within [sy, ey].
   always_comb begin
      span_s   = ey1_q - sy1_q;
      prod_s   = {10'd0, sample_data} * {8'd0, span_s};
      wave_y_s = ey1_q - 10'(prod_s >> 8);
      edge1_s  = win1_q && ((x1_q == sx1_q) || (x1_q == ex1_q) ||
                            (y1_q == sy1_q) || (y1_q == ey1_q));
      draw1_s  = win1_q && (y1_q == wave_y_s);
   end

   // Stage 2 output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_win_q <= 1'b0;
         draw_q   <= 1'b0;
         border_q <= 1'b0;
      end else begin
         in_win_q <= win1_q;
         draw_q   <= draw1_s;
         border_q <= edge1_s;
      end
   end

   assign sample_addr = addr1_q;
   assign in_win      = in_win_q;
   assign draw        = draw_q;
   assign border      = border_q;
   assign limits_err  = err_q;

endmodule
